// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - shared types and constants for the RLE row compressor.
// RLE_ROW_INDEX_EN selects the 3-byte end-of-row trailer carrying the row index.
package rle_pkg;

  typedef enum logic [1:0] {
    ACCUM    = 2'd0,
    EMIT_CNT = 2'd1,
    EMIT_VAL = 2'd2,
    EMIT_EOR = 2'd3
  } rle_state_t;

  localparam logic [7:0] EOR_MARKER = 8'h00;
  localparam int ROW_IDX_W = 16;

`ifdef RLE_ROW_INDEX_EN
  localparam int EOR_BYTES = 3;
`else
  localparam int EOR_BYTES = 1;
`endif

endpackage

// File: rtl/rle_token_serializer.sv
// rtl/rle_token_serializer.sv - turns one latched token or row marker into a byte stream.
// RLE_ROW_INDEX_EN appends row_idx (LSB first) after the 0x00 marker.
module rle_token_serializer
  import rle_pkg::*;
#(
  parameter int PIX_BYTES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clear,
  input  logic                 start,
  input  logic [7:0]           tok_cnt,
  input  logic [8*PIX_BYTES-1:0] tok_val,
  input  logic                 tok_eor,
`ifdef RLE_ROW_INDEX_EN
  input  logic [ROW_IDX_W-1:0] row_idx,
`endif
  output logic [7:0]           o_byte,
  output logic                 o_byte_valid,
  input  logic                 i_byte_ready,
  output logic                 busy,
  output logic                 tok_done,
  output logic                 eor_done
);

  localparam int PW = 8 * PIX_BYTES;
  localparam logic [1:0] VAL_LAST = 2'(PIX_BYTES - 1);
  localparam logic [1:0] EOR_LAST = 2'(EOR_BYTES - 1);

  rle_state_t      state;
  logic [PW-1:0]   val_q;
  logic [1:0]      idx;
  logic            accept;
`ifdef RLE_ROW_INDEX_EN
  logic [ROW_IDX_W-1:0] row_q;
`endif

  assign accept   = o_byte_valid && i_byte_ready;
  assign tok_done = accept && (state == EMIT_VAL) && (idx == VAL_LAST);
  assign eor_done = accept && (state == EMIT_EOR) && (idx == EOR_LAST);
  assign busy     = (state != ACCUM);

  // A new start may coincide with the last byte of the previous token, giving back-to-back tokens.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= ACCUM;
      val_q        <= '0;
      idx          <= '0;
      o_byte       <= '0;
      o_byte_valid <= 1'b0;
`ifdef RLE_ROW_INDEX_EN
      row_q        <= '0;
`endif
    end else if (clear) begin
      state        <= ACCUM;
      val_q        <= '0;
      idx          <= '0;
      o_byte       <= '0;
      o_byte_valid <= 1'b0;
`ifdef RLE_ROW_INDEX_EN
      row_q        <= '0;
`endif
    end else if (start) begin
      o_byte_valid <= 1'b1;
      idx          <= '0;
      if (tok_eor) begin
        state  <= EMIT_EOR;
        o_byte <= EOR_MARKER;
`ifdef RLE_ROW_INDEX_EN
        row_q  <= row_idx;
`endif
      end else begin
        state  <= EMIT_CNT;
        o_byte <= tok_cnt;
        val_q  <= tok_val;
      end
    end else if (accept) begin
      case (state)
        EMIT_CNT: begin
          state  <= EMIT_VAL;
          o_byte <= val_q[PW-1 -: 8];
          val_q  <= val_q << 8;
          idx    <= '0;
        end
        EMIT_VAL: begin
          if (idx == VAL_LAST) begin
            state        <= ACCUM;
            o_byte_valid <= 1'b0;
          end else begin
            o_byte <= val_q[PW-1 -: 8];
            val_q  <= val_q << 8;
            idx    <= idx + 2'd1;
          end
        end
        EMIT_EOR: begin
          if (idx == EOR_LAST) begin
            state        <= ACCUM;
            o_byte_valid <= 1'b0;
          end else begin
`ifdef RLE_ROW_INDEX_EN
            o_byte <= row_q[7:0];
            row_q  <= row_q >> 8;
`endif
            idx    <= idx + 2'd1;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: rtl/rle_row_compressor.sv
// rtl/rle_row_compressor.sv - run-length row compressor: run tracking, row close and flush sequencing.
// RLE_ROW_INDEX_EN enables the row_idx counter carried in the end-of-row trailer.
module rle_row_compressor
  import rle_pkg::*;
#(
  parameter int ROW_PIXELS = 640,
  parameter int PIX_BYTES  = 2,
  parameter int MAX_RUN    = 255
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   i_frame_start,
  input  logic [8*PIX_BYTES-1:0] i_pixel,
  input  logic                   i_pix_valid,
  output logic                   o_pix_ready,
  output logic [7:0]             o_byte,
  output logic                   o_byte_valid,
  input  logic                   i_byte_ready,
  output logic                   o_row_done
);

  localparam int PW   = 8 * PIX_BYTES;
  localparam int PC_W = (ROW_PIXELS > 1) ? $clog2(ROW_PIXELS) : 1;
  localparam logic [PC_W-1:0] PIX_LAST = PC_W'(ROW_PIXELS - 1);

  logic [7:0]      run_cnt;
  logic [PW-1:0]   run_val;
  logic [PC_W-1:0] pix_cnt;
  logic            flush_pending;
`ifdef RLE_ROW_INDEX_EN
  logic [ROW_IDX_W-1:0] row_idx;
`endif

  logic          pix_acc, row_last, run_open, extend, brk;
  logic          start, tok_eor, busy, tok_done, eor_done;
  logic [7:0]    tok_cnt;
  logic [PW-1:0] tok_val;

  assign pix_acc  = i_pix_valid && o_pix_ready && !i_frame_start;
  assign row_last = (pix_cnt == PIX_LAST);
  assign run_open = (run_cnt != 8'd0);
  assign extend   = run_open && (i_pixel == run_val) && (run_cnt < 8'(MAX_RUN));
  assign brk      = run_open && !extend;

  // A breaking pixel ships the old run; a row-closing pixel that extends ships the run including itself.
  always_comb begin
    start   = 1'b0;
    tok_eor = 1'b0;
    tok_cnt = run_cnt;
    tok_val = run_val;
    if (!i_frame_start) begin
      if (pix_acc && brk) begin
        start = 1'b1;
      end else if (pix_acc && row_last) begin
        start   = 1'b1;
        tok_cnt = run_open ? run_cnt + 8'd1 : 8'd1;
        tok_val = run_open ? run_val : i_pixel;
      end else if (tok_done && flush_pending) begin
        start   = 1'b1;
        tok_eor = !run_open;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      run_cnt       <= '0;
      run_val       <= '0;
      pix_cnt       <= '0;
      flush_pending <= 1'b0;
      o_pix_ready   <= 1'b0;
      o_row_done    <= 1'b0;
`ifdef RLE_ROW_INDEX_EN
      row_idx       <= '0;
`endif
    end else if (i_frame_start) begin
      run_cnt       <= '0;
      run_val       <= '0;
      pix_cnt       <= '0;
      flush_pending <= 1'b0;
      o_pix_ready   <= 1'b1;
      o_row_done    <= 1'b0;
`ifdef RLE_ROW_INDEX_EN
      row_idx       <= '0;
`endif
    end else begin
      o_row_done  <= eor_done;
      o_pix_ready <= !start && (!busy || tok_done || eor_done);
      if (pix_acc) begin
        pix_cnt <= row_last ? '0 : pix_cnt + PC_W'(1);
        if (row_last)
          flush_pending <= 1'b1;
        if (brk) begin
          run_val <= i_pixel;
          run_cnt <= 8'd1;
        end else if (row_last) begin
          run_cnt <= 8'd0;
        end else if (extend) begin
          run_cnt <= run_cnt + 8'd1;
        end else begin
          run_val <= i_pixel;
          run_cnt <= 8'd1;
        end
      end
      if (tok_done && flush_pending && run_open)
        run_cnt <= 8'd0;
      if (eor_done) begin
        flush_pending <= 1'b0;
        run_cnt       <= 8'd0;
`ifdef RLE_ROW_INDEX_EN
        row_idx       <= row_idx + ROW_IDX_W'(1);
`endif
      end
    end
  end

  rle_token_serializer #(
    .PIX_BYTES (PIX_BYTES)
  ) u_ser (
    .CLK          (CLK),
    .RST          (RST),
    .clear        (i_frame_start),
    .start        (start),
    .tok_cnt      (tok_cnt),
    .tok_val      (tok_val),
    .tok_eor      (tok_eor),
`ifdef RLE_ROW_INDEX_EN
    .row_idx      (row_idx),
`endif
    .o_byte       (o_byte),
    .o_byte_valid (o_byte_valid),
    .i_byte_ready (i_byte_ready),
    .busy         (busy),
    .tok_done     (tok_done),
    .eor_done     (eor_done)
  );

endmodule
